// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
// Generates the timekeeper's 1 Hz advance pulse from the system clock.
// Also runs the user set-time sequence: edit hour, edit minute, then
// commit a load into the timekeeper. Abandons the edit after an idle timeout.
module clock_set_ctrl #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk_sys,
    input  logic       sys_rst,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    output logic       tick_1hz,
    output logic       ld_en,
    output logic [4:0] ld_hour,
    output logic [5:0] ld_min,
    output logic [5:0] ld_sec,
    output logic [1:0] mode,
    output logic       blink,
    output logic [4:0] edit_hour,
    output logic [5:0] edit_min
);

    localparam int              DIV_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_HZ / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [5:0]       IDLE_LAST = 6'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [5:0]       idle_q, idle_d;
    logic [4:0]       hour_d;
    logic [5:0]       min_d;
    logic             tick_d;
    logic             ld_en_d;
    logic             blink_d;

    logic             wrap;
    logic             any_key;
    logic             do_inc;
    logic             do_dec;
    logic [4:0]       hour_up, hour_dn, hour_cap;
    logic [5:0]       min_up, min_dn, min_cap;

    // Key decoding, wrap-around field arithmetic and out-of-range capture guards.
    always_comb begin
        wrap     = (div_q == DIV_LAST);
        any_key  = key_mode | key_inc | key_dec;
        do_inc   = key_inc & ~key_dec;
        do_dec   = key_dec & ~key_inc;
        hour_up  = (edit_hour == 5'd23) ? 5'd0  : edit_hour + 5'd1;
        hour_dn  = (edit_hour == 5'd0)  ? 5'd23 : edit_hour - 5'd1;
        min_up   = (edit_min == 6'd59)  ? 6'd0  : edit_min + 6'd1;
        min_dn   = (edit_min == 6'd0)   ? 6'd59 : edit_min - 6'd1;
        hour_cap = (cur_hour > 5'd23) ? 5'd0 : cur_hour;
        min_cap  = (cur_min > 6'd59)  ? 6'd0 : cur_min;
    end

    // Next-state logic: FSM, divider, idle timer, edit fields and registered outputs.
    // The divider is held at 0 through the load-strobe cycle so the next second
    // starts fresh right after the timekeeper has been loaded.
    always_comb begin
        state_d = state_q;
        div_d   = (ld_en || wrap) ? '0 : div_q + DIV_ONE;
        idle_d  = idle_q;
        hour_d  = edit_hour;
        min_d   = edit_min;
        ld_en_d = 1'b0;

        case (state_q)
            RUN: begin
                if (key_mode) begin
                    state_d = SET_HOUR;
                    hour_d  = hour_cap;
                    min_d   = min_cap;
                    idle_d  = '0;
                end
            end
            SET_HOUR: begin
                if (key_mode) begin
                    state_d = SET_MIN;
                    idle_d  = '0;
                end else if (any_key) begin
                    idle_d = '0;
                    if (do_inc) hour_d = hour_up;
                    if (do_dec) hour_d = hour_dn;
                end else if (wrap) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = RUN;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 6'd1;
                    end
                end
            end
            SET_MIN: begin
                if (key_mode) begin
                    state_d = RUN;
                    ld_en_d = 1'b1;
                    div_d   = '0;
                    idle_d  = '0;
                end else if (any_key) begin
                    idle_d = '0;
                    if (do_inc) min_d = min_up;
                    if (do_dec) min_d = min_dn;
                end else if (wrap) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = RUN;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = RUN;
                idle_d  = '0;
            end
        endcase

        tick_d = (state_d == RUN) && (div_d == DIV_LAST) && !ld_en_d;

        if (state_d == RUN)
            blink_d = 1'b0;
        else if (state_d != state_q)
            blink_d = 1'b1;
        else if (wrap || (div_q == DIV_HALF))
            blink_d = ~blink;
        else
            blink_d = blink;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (sys_rst) begin
            state_q   <= RUN;
            div_q     <= '0;
            idle_q    <= '0;
            edit_hour <= '0;
            edit_min  <= '0;
            tick_1hz  <= 1'b0;
            ld_en     <= 1'b0;
            blink     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            idle_q    <= idle_d;
            edit_hour <= hour_d;
            edit_min  <= min_d;
            tick_1hz  <= tick_d;
            ld_en     <= ld_en_d;
            blink     <= blink_d;
        end
    end

    assign mode    = state_q;
    assign ld_hour = edit_hour;
    assign ld_min  = edit_min;
    assign ld_sec  = 6'd0;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Testbench for clock_set_ctrl with CLK_HZ=10, TIMEOUT_S=3.
// Directed scenarios check against fixed expectations; a random phase
// checks every output against a cycle-level behavioural model.
module tb_clock_set_ctrl;

    localparam int CLK_HZ    = 10;
    localparam int TIMEOUT_S = 3;

    logic       clk_sys = 1'b0;
    logic       sys_rst = 1'b0;
    logic       key_mode = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_min = '0;
    logic       tick_1hz, ld_en, blink;
    logic [4:0] ld_hour, edit_hour;
    logic [5:0] ld_min, ld_sec, edit_min;
    logic [1:0] mode;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Behavioural model: time is counted in cycles since the last anchor
    // (reset or the cycle after a load), fields use modular arithmetic.
    int m_mode, m_hour, m_min, m_idle, m_since;
    bit m_ld, m_tick, m_blink;

    clock_set_ctrl #(.CLK_HZ(CLK_HZ), .TIMEOUT_S(TIMEOUT_S)) dut (
        .clk_sys(clk_sys), .sys_rst(sys_rst),
        .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
        .cur_hour(cur_hour), .cur_min(cur_min),
        .tick_1hz(tick_1hz), .ld_en(ld_en), .ld_hour(ld_hour), .ld_min(ld_min),
        .ld_sec(ld_sec), .mode(mode), .blink(blink),
        .edit_hour(edit_hour), .edit_min(edit_min)
    );

    // Free-running system clock.
    always #5 clk_sys = ~clk_sys;

    task automatic model_reset();
        m_mode = 0; m_hour = 0; m_min = 0; m_idle = 0; m_since = 0;
        m_ld = 0; m_tick = 0; m_blink = 0;
    endtask

    task automatic model_update(input bit km, input bit ki, input bit kd, input int ch, input int cm);
        int old_mode;
        bit second_end, half_second, was_ld;
        old_mode    = m_mode;
        second_end  = (m_since % CLK_HZ) == CLK_HZ - 1;
        half_second = (m_since % CLK_HZ) == CLK_HZ / 2 - 1;
        was_ld      = m_ld;
        m_ld        = 0;
        if (km) begin
            if (m_mode == 0) begin
                m_mode = 1;
                m_hour = (ch < 24) ? ch : 0;
                m_min  = (cm < 60) ? cm : 0;
            end else if (m_mode == 1) begin
                m_mode = 2;
            end else begin
                m_mode = 0;
                m_ld   = 1;
            end
            m_idle = 0;
        end else if (m_mode != 0 && (ki || kd)) begin
            m_idle = 0;
            if (ki && !kd) begin
                if (m_mode == 1) m_hour = (m_hour + 1) % 24;
                else             m_min  = (m_min + 1) % 60;
            end else if (kd && !ki) begin
                if (m_mode == 1) m_hour = (m_hour + 23) % 24;
                else             m_min  = (m_min + 59) % 60;
            end
        end else if (m_mode != 0 && second_end) begin
            m_idle++;
            if (m_idle == TIMEOUT_S) begin
                m_mode = 0;
                m_idle = 0;
            end
        end
        if (m_mode == 0)             m_blink = 0;
        else if (m_mode != old_mode) m_blink = 1;
        else if (second_end || half_second) m_blink = !m_blink;
        if (was_ld || m_ld) m_since = 0;
        else                m_since++;
        m_tick = (m_mode == 0) && ((m_since % CLK_HZ) == CLK_HZ - 1) && !m_ld;
    endtask

    // One clock cycle with the given key pulses; outputs are valid on return.
    task automatic step(input bit km, input bit ki, input bit kd);
        key_mode = km; key_inc = ki; key_dec = kd;
        @(posedge clk_sys);
        model_update(km, ki, kd, int'(cur_hour), int'(cur_min));
        #1;
        key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
        cyc++;
    endtask

    // One-cycle synchronous reset; on return we are in cycle 1 after release.
    task automatic do_reset();
        sys_rst = 1'b1;
        key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
        @(posedge clk_sys);
        model_reset();
        #1;
        sys_rst = 1'b0;
        cyc = 1;
    endtask

    task automatic test_reset();
        logic exp_tick;
        cur_hour = 5'd7; cur_min = 6'd20;
        do_reset();
        checks++; if (tick_1hz !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got=%0b exp=0", tick_1hz); end
        checks++; if (ld_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_ld_en got=%0b exp=0", ld_en); end
        checks++; if (mode !== 2'd0) begin errors++; $display("[TB] FAIL reset_mode got=%0d exp=0", mode); end
        checks++; if (blink !== 1'b0) begin errors++; $display("[TB] FAIL reset_blink got=%0b exp=0", blink); end
        checks++; if (edit_hour !== 5'd0 || edit_min !== 6'd0) begin errors++; $display("[TB] FAIL reset_edit got=%0d:%0d exp=0:0", edit_hour, edit_min); end
        checks++; if (ld_hour !== 5'd0 || ld_min !== 6'd0 || ld_sec !== 6'd0) begin errors++; $display("[TB] FAIL reset_ld_vals got=%0d:%0d:%0d exp=0:0:0", ld_hour, ld_min, ld_sec); end
        for (int c = 2; c <= 35; c++) begin
            step(1'b0, 1'b0, 1'b0);
            exp_tick = (cyc % CLK_HZ) == 0;
            checks++; if (tick_1hz !== exp_tick) begin errors++; $display("[TB] FAIL run_tick cyc=%0d got=%0b exp=%0b", cyc, tick_1hz, exp_tick); end
            checks++; if (ld_en !== 1'b0 || mode !== 2'd0) begin errors++; $display("[TB] FAIL run_idle cyc=%0d got ld_en=%0b mode=%0d exp 0/0", cyc, ld_en, mode); end
        end
    endtask

    task automatic test_commit_wrap();
        cur_hour = 5'd23; cur_min = 6'd59;
        step(1'b1, 1'b0, 1'b0);
        checks++; if (mode !== 2'd1 || edit_hour !== 5'd23 || edit_min !== 6'd59) begin errors++; $display("[TB] FAIL enter_set got mode=%0d %0d:%0d exp 1 23:59", mode, edit_hour, edit_min); end
        checks++; if (blink !== 1'b1) begin errors++; $display("[TB] FAIL enter_blink got=%0b exp=1", blink); end
        step(1'b0, 1'b1, 1'b0);
        checks++; if (edit_hour !== 5'd0) begin errors++; $display("[TB] FAIL hour_inc_wrap got=%0d exp=0", edit_hour); end
        step(1'b1, 1'b0, 1'b0);
        checks++; if (mode !== 2'd2 || ld_en !== 1'b0) begin errors++; $display("[TB] FAIL to_set_min got mode=%0d ld_en=%0b exp 2/0", mode, ld_en); end
        step(1'b0, 1'b1, 1'b0);
        checks++; if (edit_min !== 6'd0 || edit_hour !== 5'd0) begin errors++; $display("[TB] FAIL min_inc_wrap got=%0d:%0d exp=0:0", edit_hour, edit_min); end
        step(1'b1, 1'b0, 1'b0);
        checks++; if (mode !== 2'd0 || ld_en !== 1'b1) begin errors++; $display("[TB] FAIL commit got mode=%0d ld_en=%0b exp 0/1", mode, ld_en); end
        checks++; if (ld_hour !== 5'd0 || ld_min !== 6'd0 || ld_sec !== 6'd0) begin errors++; $display("[TB] FAIL commit_vals got=%0d:%0d:%0d exp=0:0:0", ld_hour, ld_min, ld_sec); end
        checks++; if (tick_1hz !== 1'b0) begin errors++; $display("[TB] FAIL commit_tick_overlap got=%0b exp=0", tick_1hz); end
        for (int k = 1; k <= CLK_HZ; k++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++; if (ld_en !== 1'b0) begin errors++; $display("[TB] FAIL single_ld_en k=%0d got=%0b exp=0", k, ld_en); end
            checks++; if (tick_1hz !== (k == CLK_HZ)) begin errors++; $display("[TB] FAIL post_commit_tick k=%0d got=%0b exp=%0b", k, tick_1hz, k == CLK_HZ); end
        end
    endtask

    task automatic test_hour_dec_wrap();
        cur_hour = 5'd0; cur_min = 6'd30;
        step(1'b1, 1'b0, 1'b0);
        checks++; if (mode !== 2'd1 || edit_hour !== 5'd0 || edit_min !== 6'd30) begin errors++; $display("[TB] FAIL capture got mode=%0d %0d:%0d exp 1 0:30", mode, edit_hour, edit_min); end
        step(1'b0, 1'b0, 1'b1);
        checks++; if (edit_hour !== 5'd23) begin errors++; $display("[TB] FAIL hour_dec_wrap got=%0d exp=23", edit_hour); end
        step(1'b0, 1'b1, 1'b1);
        checks++; if (edit_hour !== 5'd23 || mode !== 2'd1) begin errors++; $display("[TB] FAIL inc_dec_cancel got hour=%0d mode=%0d exp 23/1", edit_hour, mode); end
    endtask

    task automatic test_mode_priority();
        step(1'b1, 1'b1, 1'b0);
        checks++; if (mode !== 2'd2 || edit_hour !== 5'd23 || edit_min !== 6'd30) begin errors++; $display("[TB] FAIL mode_priority got mode=%0d %0d:%0d exp 2 23:30", mode, edit_hour, edit_min); end
        step(1'b1, 1'b0, 1'b1);
        checks++; if (ld_en !== 1'b1 || ld_hour !== 5'd23 || ld_min !== 6'd30) begin errors++; $display("[TB] FAIL commit2 got ld_en=%0b %0d:%0d exp 1 23:30", ld_en, ld_hour, ld_min); end
    endtask

    task automatic test_timeout();
        logic       exp_blink;
        logic [1:0] exp_mode;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        checks++; if (mode !== 2'd1 || blink !== 1'b1) begin errors++; $display("[TB] FAIL timeout_entry got mode=%0d blink=%0b exp 1/1", mode, blink); end
        while (cyc < 40) begin
            step(1'b0, 1'b0, 1'b0);
            exp_mode  = (cyc <= 30) ? 2'd1 : 2'd0;
            exp_blink = (cyc <= 30) && (((cyc - 1) / 5) % 2 == 0);
            checks++; if (mode !== exp_mode) begin errors++; $display("[TB] FAIL timeout_mode cyc=%0d got=%0d exp=%0d", cyc, mode, exp_mode); end
            checks++; if (blink !== exp_blink) begin errors++; $display("[TB] FAIL timeout_blink cyc=%0d got=%0b exp=%0b", cyc, blink, exp_blink); end
            checks++; if (tick_1hz !== (cyc == 40)) begin errors++; $display("[TB] FAIL timeout_tick cyc=%0d got=%0b exp=%0b", cyc, tick_1hz, cyc == 40); end
            checks++; if (ld_en !== 1'b0) begin errors++; $display("[TB] FAIL timeout_ld_en cyc=%0d got=%0b exp=0", cyc, ld_en); end
        end
    endtask

    task automatic test_reset_mid_edit();
        cur_hour = 5'd5; cur_min = 6'd10;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        checks++; if (mode !== 2'd2 || edit_min !== 6'd11) begin errors++; $display("[TB] FAIL pre_reset_edit got mode=%0d min=%0d exp 2/11", mode, edit_min); end
        do_reset();
        checks++; if (mode !== 2'd0 || ld_en !== 1'b0 || tick_1hz !== 1'b0 || blink !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ctl got mode=%0d ld=%0b tick=%0b blink=%0b exp 0", mode, ld_en, tick_1hz, blink); end
        checks++; if (edit_hour !== 5'd0 || edit_min !== 6'd0 || ld_hour !== 5'd0 || ld_min !== 6'd0) begin errors++; $display("[TB] FAIL midreset_vals got edit=%0d:%0d ld=%0d:%0d exp 0", edit_hour, edit_min, ld_hour, ld_min); end
        for (int c = 2; c <= 12; c++) begin
            step(1'b0, 1'b0, 1'b0);
            checks++; if (tick_1hz !== (cyc == 10)) begin errors++; $display("[TB] FAIL midreset_tick cyc=%0d got=%0b exp=%0b", cyc, tick_1hz, cyc == 10); end
            checks++; if (ld_en !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ld_en cyc=%0d got=%0b exp=0", cyc, ld_en); end
        end
    endtask

    task automatic test_random();
        int  dens, r;
        bit  km, ki, kd;
        do_reset();
        dens = 8;
        for (int n = 0; n < 900; n++) begin
            if (n % 100 == 0) dens = (($urandom_range(0, 1)) != 0) ? 6 : 40;
            cur_hour = 5'($urandom_range(0, 31));
            cur_min  = 6'($urandom_range(0, 63));
            r  = int'($urandom_range(0, dens - 1));
            km = (r == 0);
            ki = (r == 1) || (r == 3);
            kd = (r == 2) || (r == 3);
            step(km, ki, kd);
            checks++; if (mode !== 2'(m_mode)) begin errors++; $display("[TB] FAIL rnd_mode cyc=%0d got=%0d exp=%0d", cyc, mode, m_mode); end
            checks++; if (tick_1hz !== m_tick) begin errors++; $display("[TB] FAIL rnd_tick cyc=%0d got=%0b exp=%0b", cyc, tick_1hz, m_tick); end
            checks++; if (ld_en !== m_ld) begin errors++; $display("[TB] FAIL rnd_ld_en cyc=%0d got=%0b exp=%0b", cyc, ld_en, m_ld); end
            checks++; if (blink !== m_blink) begin errors++; $display("[TB] FAIL rnd_blink cyc=%0d got=%0b exp=%0b", cyc, blink, m_blink); end
            checks++; if (edit_hour !== 5'(m_hour) || ld_hour !== 5'(m_hour)) begin errors++; $display("[TB] FAIL rnd_hour cyc=%0d got=%0d/%0d exp=%0d", cyc, edit_hour, ld_hour, m_hour); end
            checks++; if (edit_min !== 6'(m_min) || ld_min !== 6'(m_min)) begin errors++; $display("[TB] FAIL rnd_min cyc=%0d got=%0d/%0d exp=%0d", cyc, edit_min, ld_min, m_min); end
            checks++; if (ld_sec !== 6'd0) begin errors++; $display("[TB] FAIL rnd_ld_sec cyc=%0d got=%0d exp=0", cyc, ld_sec); end
        end
    endtask

    // Scenario sequence, then the summary line.
    initial begin
        $display("[TB] clock_set_ctrl bench start");
        test_reset();
        test_commit_wrap();
        test_hour_dec_wrap();
        test_mode_priority();
        test_timeout();
        test_reset_mid_edit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-set controller for the hour/minute/second timekeeping counter. It runs on the fast system clock and produces the timekeeper's 1 Hz advance pulse. It also runs the user set-time state machine: key-driven hour and minute editing, then a commit that loads the timekeeper. It sits between the debounced key block and the timekeeper, and drives the display blink and edit values.

## Interface
- CLK_HZ, 50_000_000: system clock cycles per second (≥4, even)
- TIMEOUT_S, 10: idle seconds in a set mode before abandoning the edit (1–63)

Ports (reset is synchronous and active-high):
- clk_sys  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- key_mode  in  1  single-cycle pulse, mode key (debounced upstream)
- key_inc  in  1  single-cycle pulse, increment key
- key_dec  in  1  single-cycle pulse, decrement key
- cur_hour  in  5  live timekeeper hour, 0–23
- cur_min  in  6  live timekeeper minute, 0–59
- tick_1hz  out  1  one-cycle advance enable to timekeeper
- ld_en  out  1  one-cycle load strobe to timekeeper
- ld_hour  out  5  load value, hour
- ld_min  out  6  load value, minute
- ld_sec  out  6  load value, second; always 0
- mode  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN
- blink  out  1  2 Hz-toggle flash enable for the field being edited
- edit_hour  out  5  hour shown while editing
- edit_min  out  6  minute shown while editing

## Operation
- Divider div runs from 0 to CLK_HZ-1, then wraps to 0. It is free-running in all modes. A wrap is one "second".
- tick_1hz asserts on a wrap in RUN only. It is suppressed in SET_HOUR and SET_MIN, so the timekeeper is frozen while editing.
- blink is 0 in RUN. In the set modes it toggles when div = CLK_HZ/2-1 and when div = CLK_HZ-1. It is forced to 1 on entry to any set mode.
- FSM transitions:
  - RUN + key_mode → SET_HOUR. Captures edit_hour←cur_hour and edit_min←cur_min. An out-of-range value is captured as 0.
  - SET_HOUR + key_mode → SET_MIN.
  - SET_MIN + key_mode → RUN. Pulses ld_en with ld_hour=edit_hour, ld_min=edit_min, ld_sec=0. Resets div to 0.
- Editing in SET_HOUR: key_inc gives 23→0 wrap, otherwise +1. key_dec gives 0→23 wrap, otherwise -1.
- Editing in SET_MIN: the same, with 59/0 wraps.
- In RUN, key_inc and key_dec are ignored.
- Simultaneous keys:
  - key_mode has priority; a same-cycle key_inc or key_dec is ignored.
  - key_inc together with key_dec (no key_mode) causes no change.
- Timeout:
  - An idle counter counts div wraps while in a set mode. It clears on any key pulse and on mode entry.
  - When it reaches TIMEOUT_S, the FSM returns to RUN with no ld_en, discarding the edit. div is not reset.
- ld_hour and ld_min mirror edit_hour and edit_min at all times. ld_sec is constant 0.

## Timing
- All outputs are registered.
- Reset values: tick_1hz=0, ld_en=0, ld_hour=0, ld_min=0, ld_sec=0, mode=0, blink=0, edit_hour=0, edit_min=0. div=0 and the idle counter is 0.
- The first tick_1hz is high in cycle CLK_HZ, counting the first cycle with sys_rst low as cycle 1. After that, it pulses every CLK_HZ cycles in RUN.
- Key to response latency is 1 cycle. mode, edit_* and ld_en change in the cycle after the key pulse is sampled.
- After commit, the next tick_1hz occurs CLK_HZ cycles after the ld_en cycle. ld_en and tick_1hz are never high in the same cycle.
- The timeout fires on the TIMEOUT_S-th wrap after the last key. mode reads 0 one cycle after that wrap.
- Reset mid-edit returns to RUN with all outputs at reset values. No ld_en is emitted.

## Test plan
Benches use CLK_HZ=10, TIMEOUT_S=3.

- Reset release with no keys for 35 cycles → tick_1hz high in cycles 10, 20 and 30 only. mode=0, ld_en never asserted.
- cur_hour=23, cur_min=59, then key_mode, key_inc, key_mode, key_inc, key_mode → mode goes 1, 2, 0. edit_hour=0, edit_min=0. One ld_en cycle with ld_hour=0, ld_min=0, ld_sec=0.
- cur_hour=0: key_mode then key_dec → edit_hour=23. key_inc together with key_dec → edit_hour stays 23.
- key_mode together with key_inc in SET_HOUR → mode=2, edit_hour unchanged.
- In SET_HOUR, no keys for 3 wraps → mode=0, no ld_en, no tick_1hz during set mode. tick_1hz resumes on the next wrap.
- In SET_MIN, with edit_min changed, assert sys_rst for 1 cycle → all outputs 0, mode=0, no ld_en. First tick_1hz comes 10 cycles after release.
